// File: rtl/brick_ctrl_pkg.sv
// Shared brick-field geometry, hit-FSM state codes and derived widths
// used by the brick controller and its coordinate locator.
package brick_ctrl_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 6;
    localparam int X0      = 140;
    localparam int Y0      = 200;
    localparam int BRICK_W = 80;
    localparam int BRICK_H = 20;
    localparam int GAP_X   = 20;
    localparam int GAP_Y   = 10;

    localparam int COORD_W = 11;
    localparam int BRICK_N = ROWS * COLS;
    localparam int LEFT_W  = $clog2(BRICK_N + 1);
    localparam int IDX_W   = $clog2(BRICK_N);
    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);

    // Top-level hit handshake states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    // Locator states
    localparam logic [1:0] LOC_IDLE = 2'd0;
    localparam logic [1:0] LOC_X    = 2'd1;
    localparam logic [1:0] LOC_Y    = 2'd2;

endpackage

// File: rtl/brick_locate.sv
// Sequential coordinate-to-cell resolver: walks one column per cycle, then one
// row per cycle, and reports the cell or a miss with a one-cycle done pulse.
module brick_locate
    import brick_ctrl_pkg::*;
#(
    parameter int X_ORG  = X0,
    parameter int Y_ORG  = Y0,
    parameter int SPAN_X = BRICK_W,
    parameter int SPAN_Y = BRICK_H,
    parameter int STEP_X = BRICK_W + GAP_X,
    parameter int STEP_Y = BRICK_H + GAP_Y,
    parameter int N_X    = COLS,
    parameter int N_Y    = ROWS,
    parameter int CW     = $clog2(N_X),
    parameter int RW     = $clog2(N_Y)
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               done_o,
    output logic               miss_o,
    output logic [CW-1:0]      col_o,
    output logic [RW-1:0]      row_o
);

    localparam int AW = COORD_W + 1;
    localparam logic [AW-1:0] XB   = AW'(X_ORG);
    localparam logic [AW-1:0] YB   = AW'(Y_ORG);
    localparam logic [AW-1:0] SX   = AW'(SPAN_X);
    localparam logic [AW-1:0] SY   = AW'(SPAN_Y);
    localparam logic [AW-1:0] STX  = AW'(STEP_X);
    localparam logic [AW-1:0] STY  = AW'(STEP_Y);
    localparam logic [CW-1:0] LAST_COL = CW'(N_X - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N_Y - 1);

    logic [1:0]         st_q, st_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [AW-1:0]      base_q, base_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic               done_q, done_d, miss_q, miss_d;
    logic [AW-1:0]      x_ext, y_ext;

    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        col_d  = col_q;
        row_d  = row_q;
        done_d = 1'b0;
        miss_d = miss_q;
        case (st_q)
            LOC_IDLE: begin
                if (start_i) begin
                    x_d    = x_i;
                    y_d    = y_i;
                    base_d = XB;
                    col_d  = '0;
                    st_d   = LOC_X;
                end
            end
            LOC_X: begin
                if (x_ext < base_q) begin
                    done_d = 1'b1;
                    miss_d = 1'b1;
                    st_d   = LOC_IDLE;
                end else if (x_ext < base_q + SX) begin
                    base_d = YB;
                    row_d  = '0;
                    st_d   = LOC_Y;
                end else if (col_q == LAST_COL) begin
                    done_d = 1'b1;
                    miss_d = 1'b1;
                    st_d   = LOC_IDLE;
                end else begin
                    base_d = base_q + STX;
                    col_d  = col_q + CW'(1);
                end
            end
            LOC_Y: begin
                if (y_ext < base_q) begin
                    done_d = 1'b1;
                    miss_d = 1'b1;
                    st_d   = LOC_IDLE;
                end else if (y_ext < base_q + SY) begin
                    done_d = 1'b1;
                    miss_d = 1'b0;
                    st_d   = LOC_IDLE;
                end else if (row_q == LAST_ROW) begin
                    done_d = 1'b1;
                    miss_d = 1'b1;
                    st_d   = LOC_IDLE;
                end else begin
                    base_d = base_q + STY;
                    row_d  = row_q + RW'(1);
                end
            end
            default: st_d = LOC_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset || flush_i) begin
            st_q   <= LOC_IDLE;
            done_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            done_q <= done_d;
            miss_q <= miss_d;
        end
    end

    // Datapath registers carry no reset; they are loaded before use.
    always_ff @(posedge pclk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        base_q <= base_d;
        col_q  <= col_d;
        row_q  <= row_d;
    end

    assign done_o = done_q;
    assign miss_o = miss_q;
    assign col_o  = col_q;
    assign row_o  = row_q;

endmodule

// File: rtl/brick_ctrl.sv
// Arkanoid brick field: alive bitmap, per-pixel lookup, req/ack hit port with
// removals deferred to the vblank rising edge so a drawn frame never tears.
module brick_ctrl
    import brick_ctrl_pkg::*;
(
    input  logic               pclk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hcount_in,
    input  logic [COORD_W-1:0] vcount_in,
    input  logic               vblnk_in,
    input  logic               level_load,
    input  logic               hit_req,
    input  logic [COORD_W-1:0] hit_x,
    input  logic [COORD_W-1:0] hit_y,
    output logic               hit_ack,
    output logic               hit_valid,
    output logic               brick_px,
    output logic [LEFT_W-1:0]  bricks_left,
    output logic               board_clear
);

    logic [BRICK_N-1:0] bitmap_q, bitmap_d, pending_q, pending_d;
    logic [BRICK_N-1:0] pix_mask, sel, set_mask;
    logic [1:0]         state_q, state_d;
    logic [LEFT_W-1:0]  left_q, left_d;
    logic               clear_q, ack_q, ack_d, valid_q, valid_d;
    logic               pix_q, vblnk_q, rise, start, resolve, hit_ok;
    logic               loc_done, loc_miss;
    logic [COL_W-1:0]   loc_col;
    logic [ROW_W-1:0]   loc_row;

    function automatic logic [LEFT_W-1:0] popcount(input logic [BRICK_N-1:0] v);
        logic [LEFT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BRICK_N; i++) cnt = cnt + LEFT_W'(v[i]);
        return cnt;
    endfunction

    function automatic logic in_span(input logic [COORD_W-1:0] v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

    brick_locate u_locate (
        .pclk    (pclk),
        .reset   (reset),
        .flush_i (level_load),
        .start_i (start),
        .x_i     (hit_x),
        .y_i     (hit_y),
        .done_o  (loc_done),
        .miss_o  (loc_miss),
        .col_o   (loc_col),
        .row_o   (loc_row)
    );

    assign rise     = vblnk_in & ~vblnk_q;
    assign start    = (state_q == ST_IDLE) && hit_req && !level_load;
    assign resolve  = (state_q == ST_LOC) && loc_done;
    assign sel      = BRICK_N'(1) << (IDX_W'(loc_row) * IDX_W'(COLS) + IDX_W'(loc_col));
    // A brick already queued for removal must not be counted twice.
    assign hit_ok   = !loc_miss && |(bitmap_q & ~pending_q & sel);
    assign set_mask = (resolve && hit_ok) ? sel : '0;

    always_comb begin
        pix_mask = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix_mask[r*COLS + c] = in_span(hcount_in, X0 + c*(BRICK_W + GAP_X), BRICK_W) &&
                                       in_span(vcount_in, Y0 + r*(BRICK_H + GAP_Y), BRICK_H);
    end

    always_comb begin
        bitmap_d  = bitmap_q;
        pending_d = pending_q;
        left_d    = left_q;
        if (rise) begin
            bitmap_d  = bitmap_q & ~pending_q;
            pending_d = '0;
            left_d    = left_q - popcount(pending_q);
        end
        // A hit resolved on the commit edge lands after the clear.
        pending_d = pending_d | set_mask;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit_req) state_d = ST_LOC;
            ST_LOC:  if (loc_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_WAIT;
            ST_WAIT: if (!hit_req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d   = resolve;
        valid_d = resolve && hit_ok;
    end

    always_ff @(posedge pclk) begin
        if (reset || level_load) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            bitmap_q  <= '1;
            pending_q <= '0;
            left_q    <= LEFT_W'(BRICK_N);
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            bitmap_q  <= bitmap_d;
            pending_q <= pending_d;
            left_q    <= left_d;
            clear_q   <= (left_q == '0);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            pix_q   <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            pix_q   <= |(bitmap_q & pix_mask);
            vblnk_q <= vblnk_in;
        end
    end

    assign hit_ack     = ack_q;
    assign hit_valid   = valid_q;
    assign brick_px    = pix_q;
    assign bricks_left = left_q;
    assign board_clear = clear_q;

endmodule

// File: tb/tb_brick_ctrl.sv
// Directed bench for brick_ctrl: pixel lookup, hit handshake, vblank commit,
// misses, double hits, board clear, level_load abort and commit/hit collision.
module tb_brick_ctrl;

    logic        pclk = 1'b0;
    logic        reset, vblnk_in, level_load, hit_req;
    logic [10:0] hcount_in, vcount_in, hit_x, hit_y;
    logic        hit_ack, hit_valid, brick_px, board_clear;
    logic [4:0]  bricks_left;

    int n_cmp = 0;
    int n_bad = 0;

    brick_ctrl dut (
        .pclk        (pclk),
        .reset       (reset),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .vblnk_in    (vblnk_in),
        .level_load  (level_load),
        .hit_req     (hit_req),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .hit_ack     (hit_ack),
        .hit_valid   (hit_valid),
        .brick_px    (brick_px),
        .bricks_left (bricks_left),
        .board_clear (board_clear)
    );

    always #5 pclk = ~pclk;

    task automatic probe(input int x, input int y, output logic px);
        @(negedge pclk);
        hcount_in = 11'(x);
        vcount_in = 11'(y);
        @(posedge pclk); #1;
        px = brick_px;
    endtask

    task automatic hit(input int x, input int y, output logic got, output logic valid, output int cyc);
        @(negedge pclk);
        hit_x = 11'(x); hit_y = 11'(y); hit_req = 1'b1;
        got = 1'b0; valid = 1'b0; cyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge pclk); #1;
            cyc++;
            if (hit_ack) begin
                got = 1'b1;
                valid = hit_valid;
            end
        end
        @(negedge pclk);
        hit_req = 1'b0;
        repeat (2) @(posedge pclk);
    endtask

    task automatic vblank_rise();
        @(negedge pclk);
        vblnk_in = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic vblank_fall();
        @(negedge pclk);
        vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
    endtask

    task automatic pulse_load();
        @(negedge pclk);
        level_load = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        level_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge pclk); #1;
        n_cmp++; if (bricks_left !== 5'd24) begin n_bad++; $display("FAIL reset_left: got %0d want 24", bricks_left); end
        n_cmp++; if (board_clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear: got %b want 0", board_clear); end
        n_cmp++; if (hit_ack !== 1'b0 || hit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b%b want 00", hit_ack, hit_valid); end
        n_cmp++; if (brick_px !== 1'b0) begin n_bad++; $display("FAIL reset_px: got %b want 0", brick_px); end
        @(negedge pclk);
        reset = 1'b0;
    endtask

    task automatic test_pixel();
        logic px;
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL px_150_205: got %b want 1", px); end
        probe(230, 205, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL px_gap_230: got %b want 0", px); end
        probe(219, 219, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL px_corner: got %b want 1", px); end
        probe(220, 205, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL px_right_edge: got %b want 0", px); end
        probe(219, 220, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL px_bottom_edge: got %b want 0", px); end
        probe(139, 200, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL px_left_out: got %b want 0", px); end
        probe(719, 309, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL px_last_brick: got %b want 1", px); end
    endtask

    task automatic test_hit_commit();
        logic got, valid, px;
        int cyc;
        hit(150, 205, got, valid, cyc);
        n_cmp++; if (got !== 1'b1 || valid !== 1'b1) begin n_bad++; $display("FAIL hit00_resp: got ack=%b valid=%b want 1 1", got, valid); end
        n_cmp++; if (cyc > 12) begin n_bad++; $display("FAIL hit00_latency: got %0d want <=12", cyc); end
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL hit00_px_pending: got %b want 1", px); end
        n_cmp++; if (bricks_left !== 5'd24) begin n_bad++; $display("FAIL hit00_left_pre: got %0d want 24", bricks_left); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd23) begin n_bad++; $display("FAIL hit00_left_post: got %0d want 23", bricks_left); end
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL hit00_px_post: got %b want 0", px); end
        vblank_fall();
    endtask

    task automatic test_miss();
        logic got, valid;
        int cyc;
        int xs [5] = '{230, 100, 720, 150, 150};
        int ys [5] = '{205, 100, 205, 225, 320};
        for (int i = 0; i < 5; i++) begin
            hit(xs[i], ys[i], got, valid, cyc);
            n_cmp++;
            if (got !== 1'b1 || valid !== 1'b0 || cyc > 12) begin
                n_bad++;
                $display("FAIL miss_%0d_%0d: got ack=%b valid=%b cyc=%0d want 1 0 <=12", xs[i], ys[i], got, valid, cyc);
            end
        end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd23) begin n_bad++; $display("FAIL miss_left: got %0d want 23", bricks_left); end
        vblank_fall();
    endtask

    task automatic test_back_to_back();
        logic got, valid;
        int cyc;
        hit(250, 235, got, valid, cyc);
        n_cmp++; if (got !== 1'b1 || valid !== 1'b1) begin n_bad++; $display("FAIL double_first: got ack=%b valid=%b want 1 1", got, valid); end
        hit(250, 235, got, valid, cyc);
        n_cmp++; if (got !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL double_second: got ack=%b valid=%b want 1 0", got, valid); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd22) begin n_bad++; $display("FAIL double_left: got %0d want 22", bricks_left); end
        vblank_fall();
    endtask

    task automatic test_worst_latency();
        logic got, valid;
        int cyc;
        hit(680, 300, got, valid, cyc);
        n_cmp++; if (got !== 1'b1 || valid !== 1'b1) begin n_bad++; $display("FAIL worst_resp: got ack=%b valid=%b want 1 1", got, valid); end
        n_cmp++; if (cyc > 12) begin n_bad++; $display("FAIL worst_latency: got %0d want <=12", cyc); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd21) begin n_bad++; $display("FAIL worst_left: got %0d want 21", bricks_left); end
        vblank_fall();
    endtask

    task automatic test_clear_all();
        logic got, valid, px;
        int cyc, n_got, n_valid;
        n_got = 0; n_valid = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 6; c++) begin
                hit(180 + 100*c, 210 + 30*r, got, valid, cyc);
                if (got) n_got++;
                if (got && valid) n_valid++;
            end
        n_cmp++; if (n_got != 24) begin n_bad++; $display("FAIL clear_acks: got %0d want 24", n_got); end
        n_cmp++; if (n_valid != 21) begin n_bad++; $display("FAIL clear_valids: got %0d want 21", n_valid); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd0 || board_clear !== 1'b0) begin n_bad++; $display("FAIL clear_edge: got left=%0d clear=%b want 0 0", bricks_left, board_clear); end
        @(posedge pclk); #1;
        n_cmp++; if (board_clear !== 1'b1) begin n_bad++; $display("FAIL clear_flag: got %b want 1", board_clear); end
        vblank_fall();
        pulse_load();
        n_cmp++; if (bricks_left !== 5'd24 || board_clear !== 1'b0) begin n_bad++; $display("FAIL reload: got left=%0d clear=%b want 24 0", bricks_left, board_clear); end
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL reload_px: got %b want 1", px); end
    endtask

    task automatic test_abort();
        logic got, valid, px, seen;
        int cyc;
        hit(150, 205, got, valid, cyc);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL abort_prehit: got %b want 1", valid); end
        @(negedge pclk);
        hit_x = 11'd680; hit_y = 11'd300; hit_req = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        level_load = 1'b1; hit_req = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        level_load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge pclk); #1;
            if (hit_ack) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: got %b want 0", seen); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd24) begin n_bad++; $display("FAIL abort_pending_dropped: got %0d want 24", bricks_left); end
        vblank_fall();
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL abort_px: got %b want 1", px); end
        hit(680, 300, got, valid, cyc);
        n_cmp++; if (got !== 1'b1 || valid !== 1'b1) begin n_bad++; $display("FAIL abort_rehit: got ack=%b valid=%b want 1 1", got, valid); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd23) begin n_bad++; $display("FAIL abort_rehit_left: got %0d want 23", bricks_left); end
        vblank_fall();
    endtask

    task automatic test_commit_collision();
        logic got, valid, px;
        int cyc;
        hit(250, 235, got, valid, cyc);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL coll_prehit: got %b want 1", valid); end
        // Brick (0,0) resolves on the 4th edge after the request; align vblank to it.
        @(negedge pclk);
        hit_x = 11'd150; hit_y = 11'd205; hit_req = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        vblnk_in = 1'b1;
        @(posedge pclk); #1;
        n_cmp++; if (hit_ack !== 1'b1 || hit_valid !== 1'b1) begin n_bad++; $display("FAIL coll_ack: got ack=%b valid=%b want 1 1", hit_ack, hit_valid); end
        n_cmp++; if (bricks_left !== 5'd22) begin n_bad++; $display("FAIL coll_left: got %0d want 22", bricks_left); end
        @(negedge pclk);
        hit_req = 1'b0; vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b1) begin n_bad++; $display("FAIL coll_px_deferred: got %b want 1", px); end
        vblank_rise();
        n_cmp++; if (bricks_left !== 5'd21) begin n_bad++; $display("FAIL coll_left_next: got %0d want 21", bricks_left); end
        probe(150, 205, px);
        n_cmp++; if (px !== 1'b0) begin n_bad++; $display("FAIL coll_px_next: got %b want 0", px); end
        vblank_fall();
    endtask

    initial begin
        reset = 1'b1; vblnk_in = 1'b0; level_load = 1'b0; hit_req = 1'b0;
        hcount_in = '0; vcount_in = '0; hit_x = '0; hit_y = '0;
        test_reset();
        test_pixel();
        test_hit_commit();
        test_miss();
        test_back_to_back();
        test_worst_latency();
        test_clear_all();
        test_abort();
        test_commit_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
